// File: rtl/pipeline_scoreboard_if.sv
// Decode-side request and scoreboard control bundle for pipeline_scoreboard.
// The master drives the D-stage view; the slave returns hazard controls.
interface pipeline_scoreboard_if #(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int SELW         = 3,
  parameter int CNTW         = 16
);
  logic                    freeze;
  logic                    branchTakenE;
  logic                    issueValidD;
  logic [ADDRESSWIDTH-1:0] reg1AddressD;
  logic [ADDRESSWIDTH-1:0] reg2AddressD;
  logic                    reg1UsedD;
  logic                    reg2UsedD;
  logic [ADDRESSWIDTH-1:0] regDestinationAddressD;
  logic                    writeEnableD;
  logic [SELW-1:0]         readyStageD;
  logic [SELW-1:0]         data1ForwardSelectorE;
  logic [SELW-1:0]         data2ForwardSelectorE;
  logic                    stallF;
  logic                    stallD;
  logic                    flushD;
  logic                    flushE;
  logic [REGNUM-1:0]       busyMask;
  logic [CNTW-1:0]         stallCount;
  logic [CNTW-1:0]         flushCount;

  modport master (
    output freeze, branchTakenE, issueValidD,
    output reg1AddressD, reg2AddressD,
    output reg1UsedD, reg2UsedD,
    output regDestinationAddressD, writeEnableD,
    output readyStageD,
    input  data1ForwardSelectorE, data2ForwardSelectorE,
    input  stallF, stallD, flushD, flushE,
    input  busyMask, stallCount, flushCount
  );

  modport slave (
    input  freeze, branchTakenE, issueValidD,
    input  reg1AddressD, reg2AddressD,
    input  reg1UsedD, reg2UsedD,
    input  regDestinationAddressD, writeEnableD,
    input  readyStageD,
    output data1ForwardSelectorE, data2ForwardSelectorE,
    output stallF, stallD, flushD, flushE,
    output busyMask, stallCount, flushCount
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Tracks in-flight writers from E to WB and derives load-use stalls,
// forwarding selectors, flushes, a busy mask and event counters.
module pipeline_scoreboard #(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int STAGES       = 3,
  parameter int SELW         = 3,
  parameter int CNTW         = 16
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_scoreboard_if.slave sb
);
  localparam int RW = SELW + 1;

  logic [STAGES:1]         r_valid;
  logic [STAGES:1]         r_wr;
  logic [ADDRESSWIDTH-1:0] r_dst [1:STAGES];
  logic [RW-1:0]           r_rdy [1:STAGES];
  logic [ADDRESSWIDTH-1:0] r_src [2];
  logic [1:0]              r_used;
  logic [CNTW-1:0]         r_stallCnt;
  logic [CNTW-1:0]         r_flushCnt;

  logic [ADDRESSWIDTH-1:0] w_srcD [2];
  logic [1:0]              w_useD;
  logic [1:0]              w_hit;
  logic [1:0]              w_haz;
  logic [1:0]              w_fwdHit;
  logic [SELW-1:0]         w_sel [2];
  logic                    w_stall;
  logic                    w_stallD;
  logic                    w_flushD;
  logic                    w_flushE;
  logic                    w_issue;
  logic [RW-1:0]           w_rdyIn;
  logic [RW-1:0]           w_rdyClamp;
  logic [REGNUM-1:0]       w_busy;

  assign w_srcD[0] = sb.reg1AddressD;
  assign w_srcD[1] = sb.reg2AddressD;
  assign w_useD    = {sb.reg2UsedD, sb.reg1UsedD};

  // Ascending k visits the youngest writer first; older ones are ignored.
  always_comb begin
    w_hit = '0;
    w_haz = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (!w_hit[s] && r_valid[k] && r_wr[k]
            && r_dst[k] == w_srcD[s]) begin
          w_hit[s] = 1'b1;
          w_haz[s] = (k + 1) < int'(r_rdy[k]);
        end
      end
    end
  end

  always_comb begin
    w_fwdHit = '0;
    for (int s = 0; s < 2; s++) begin
      w_sel[s] = '0;
      for (int k = 2; k <= STAGES; k++) begin
        if (r_used[s] && !w_fwdHit[s] && r_valid[k] && r_wr[k]
            && r_dst[k] == r_src[s] && k >= int'(r_rdy[k])) begin
          w_fwdHit[s] = 1'b1;
          w_sel[s]    = SELW'(k - 1);
        end
      end
    end
  end

  assign w_stall  = sb.issueValidD & |(w_useD & w_haz);
  assign w_stallD = w_stall | sb.freeze;
  assign w_flushE = (w_stall | sb.branchTakenE) & ~sb.freeze;
  assign w_flushD = sb.branchTakenE & ~sb.freeze;
  assign w_issue  = sb.issueValidD & ~w_stall & ~sb.branchTakenE;

  assign w_rdyIn = {1'b0, sb.readyStageD};

  always_comb begin
    w_rdyClamp = w_rdyIn;
    if (w_rdyIn < RW'(2))
      w_rdyClamp = RW'(2);
    else if (w_rdyIn > RW'(STAGES))
      w_rdyClamp = RW'(STAGES);
  end

  always_comb begin
    w_busy = '0;
    for (int k = 1; k <= STAGES; k++)
      if (r_valid[k] && r_wr[k])
        w_busy[r_dst[k]] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_used  <= '0;
      r_src[0] <= '0;
      r_src[1] <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_dst[k] <= '0;
        r_rdy[k] <= '0;
      end
    end else if (!sb.freeze) begin
      for (int k = STAGES; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_dst[k]   <= r_dst[k-1];
        r_rdy[k]   <= r_rdy[k-1];
      end
      r_valid[1] <= w_issue;
      r_wr[1]    <= w_issue & sb.writeEnableD;
      r_dst[1]   <= sb.regDestinationAddressD;
      r_rdy[1]   <= w_rdyClamp;
      r_src[0]   <= w_srcD[0];
      r_src[1]   <= w_srcD[1];
      r_used     <= w_useD & {2{w_issue}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallD && r_stallCnt != '1)
        r_stallCnt <= r_stallCnt + CNTW'(1);
      if (w_flushD && r_flushCnt != '1)
        r_flushCnt <= r_flushCnt + CNTW'(1);
    end
  end

  assign sb.data1ForwardSelectorE = w_sel[0];
  assign sb.data2ForwardSelectorE = w_sel[1];
  assign sb.stallF     = w_stallD;
  assign sb.stallD     = w_stallD;
  assign sb.flushD     = w_flushD;
  assign sb.flushE     = w_flushE;
  assign sb.busyMask   = w_busy;
  assign sb.stallCount = r_stallCnt;
  assign sb.flushCount = r_flushCnt;
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameter REGNUM, 16, number of architectural registers.
REQ-002 Parameter ADDRESSWIDTH, 4, register address width.
REQ-003 Parameter STAGES, 3, post-decode stages tracked, k=1 is E and k=STAGES is WB; legal range 2..8.
REQ-004 Parameter SELW, 3, width of stage-index and forward-selector fields.
REQ-005 Parameter CNTW, 16, width of the performance counters.
REQ-006 The block has one clock; reset is asynchronous and active-high. Ports: clock in 1, system clock; reset in 1, async active-high clear.
REQ-007 freeze  in  1  global pipeline hold, for example a memory wait.
REQ-008 branchTakenE  in  1  branch resolved taken in E.
REQ-009 issueValidD  in  1  D holds a real instruction.
REQ-010 reg1AddressD, reg2AddressD  in  ADDRESSWIDTH each  D source registers; reg1UsedD, reg2UsedD  in  1 each  source is read.
REQ-011 regDestinationAddressD  in  ADDRESSWIDTH  D destination; writeEnableD  in  1  D writes a register.
REQ-012 readyStageD  in  SELW  first stage whose output can forward this result (ALU=2, load=STAGES).
REQ-013 data1ForwardSelectorE, data2ForwardSelectorE  out  SELW each  0 = use register-file value, n = forward from stage n+1.
REQ-014 stallF, stallD, flushD, flushE  out  1 each  pipeline controls.
REQ-015 busyMask  out  REGNUM  bit r set when any tracked entry will write r.
REQ-016 stallCount, flushCount  out  CNTW each  saturating event counters.

Function
REQ-017 State is an entry per stage k=1..STAGES: {valid, wr, dst, ready}; stage 1 also holds src1/src2 address and used bits.
REQ-018 Advance (freeze=0): entry k moves to k+1 on each clock edge; the entry at STAGES retires.
REQ-019 Stage 1 loads the D instruction when issueValidD=1, stall=0 and branchTakenE=0; otherwise stage 1 loads a bubble (valid=0).
REQ-020 readyStageD values below 2 are clamped to 2 and values above STAGES are clamped to STAGES.
REQ-021 Load-use stall: stall=1 when, for a used D source s, the youngest valid, writing entry at stage k with dst==s has k+1 < ready.
REQ-022 Only the youngest matching entry is considered; older matches never cause a stall.
REQ-023 Forward selector for E source x: the smallest k in 2..STAGES with valid, wr, dst==x and k>=ready yields k-1; if there is no such entry, or x is unused, the selector is 0.
REQ-024 The register file is write-through, so a WB write and a D read in the same cycle need no scoreboard action.
REQ-025 Control outputs: stallF = stallD = stall|freeze; flushE = (stall|branchTakenE) & !freeze; flushD = branchTakenE & !freeze.
REQ-026 branchTakenE together with a stall: the flush wins, stage 1 loads a bubble, and stallF/stallD follow REQ-025.
REQ-027 freeze=1: all entries hold, no issue, branchTakenE is ignored, and stallCount increments.
REQ-028 busyMask = OR over valid & wr entries of onehot(dst); the mask is combinational from state.
REQ-029 stallCount increments in each cycle with stallD=1; flushCount increments in each cycle with flushD=1; both saturate at all-ones.
REQ-030 All outputs other than the counters are combinational from state and current inputs; the counters are registered.

Reset
REQ-031 While reset=1, all entries are cleared to valid=0, stage-1 sources to used=0, and both counters to 0, regardless of clock.
REQ-032 Reset outputs: forward selectors 0, busyMask 0, stall/flush outputs 0 unless driven by inputs.
REQ-033 Reset asserted mid-stall or mid-freeze discards all in-flight entries; after deassertion the first valid issue is accepted with no stall.

Verification
REQ-034 With STAGES=3, issue ALU r3 (ready=2), then next cycle a consumer of r3 -> no stall; consumer in E sees data1ForwardSelectorE=1.
REQ-035 Issue load r5 (ready=3), then an immediate consumer of r5 -> one-cycle stall (stallD=1, flushE=1, stallCount=1); the following cycle the selector is 2.
REQ-036 Two writers of r7 (load, then ALU) followed by a consumer of r7 -> no stall; the selector picks the ALU entry (1), not the load.
REQ-037 branchTakenE=1 with issueValidD=1 -> flushD=1, flushE=1, stage-1 bubble, busyMask unchanged for that destination, flushCount increments.
REQ-038 Hold freeze=1 for 4 cycles with a load in stage 1 -> busyMask is constant, no retirement, stallCount=4; pulse reset -> busyMask 0, counters 0.
REQ-039 Force stallCount to all-ones-1 via sustained stalls (CNTW=4) -> the count saturates at 15 and never wraps.
